// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding,
// register-file constants and the bundle of per-stage control strobes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } ctrl_state_e;

    localparam int REG_AW_DEF = 5;
    localparam logic [REG_AW_DEF-1:0] REG_X0 = '0;

    // ex_mem_flush is not stored here: it is always ex_stall & ~mem_stall.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_stall;
        logic mem_stall;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_RESET   = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_FREEZE  = '{ex_stall: 1'b1, mem_stall: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_MDU     = '{ex_stall: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_BRANCH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                       default: 1'b0};
    localparam ctrl_t CTRL_BUBBLE  = '{id_ex_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-information inputs and stall/flush outputs exchanged between the
// pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_is_mdu;
    logic              ex_branch_taken;
    logic              mem_access;
    logic              dmem_ready;

    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_stall;
    logic              ex_mem_flush;
    logic              mem_stall;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_is_mdu, ex_branch_taken, mem_access, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_stall,
               ex_mem_flush, mem_stall, state, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_is_mdu, ex_branch_taken, mem_access, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_stall,
               ex_mem_flush, mem_stall, state, stall_cnt
    );
endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
// Writes to x0 are discarded by the register file, so they never create a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_mem_read_i,
    output logic              hazard_o
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign hazard_o = ex_mem_read_i && (ex_rd_i != REG_AW'(REG_X0)) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: small registered FSM (RUN / MEM_WAIT / MDU_WAIT)
// with same-cycle combinational control strobes for every pipeline register.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam int MC_W = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;

    ctrl_state_e      state_q, state_d;
    logic [MC_W-1:0]  mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        load_use;
    ctrl_t       ctl;
    ctrl_t       ex_ctl;
    ctrl_state_e ex_next;
    logic        ex_load_cnt;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use (
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .id_use_rs1_i  (bus.id_use_rs1),
        .id_use_rs2_i  (bus.id_use_rs2),
        .ex_rd_i       (bus.ex_rd),
        .ex_mem_read_i (bus.ex_mem_read),
        .hazard_o      (load_use)
    );

    // Rules 2-4, shared by RUN (when memory is not waiting) and the MEM_WAIT release.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ex_ctl      = CTRL_DEFAULT;
        ex_next     = RUN;
        ex_load_cnt = 1'b0;
        if (bus.ex_is_mdu) begin
            ex_ctl      = CTRL_MDU;
            ex_next     = MDU_WAIT;
            ex_load_cnt = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ex_ctl = CTRL_BRANCH;
        end else if (load_use) begin
            ex_ctl = CTRL_BUBBLE;
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        ctl       = CTRL_DEFAULT;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (bus.mem_access && !bus.dmem_ready) begin
                    ctl     = CTRL_FREEZE;
                    state_d = MEM_WAIT;
                end else begin
                    ctl     = ex_ctl;
                    state_d = ex_next;
                    if (ex_load_cnt) mdu_cnt_d = MC_W'(MDU_LAT - 2);
                end
            end
            MDU_WAIT: begin
                if (mdu_cnt_q != '0) begin
                    ctl       = CTRL_MDU;
                    mdu_cnt_d = mdu_cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (!rst_n) ctl = CTRL_RESET;
    end

    assign stall_cnt_d = (!ctl.pc_write && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1)
                                                              : stall_cnt_q;

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_write     = ctl.pc_write;
    assign bus.if_id_write  = ctl.if_id_write;
    assign bus.if_id_flush  = ctl.if_id_flush;
    assign bus.id_ex_flush  = ctl.id_ex_flush;
    assign bus.ex_stall     = ctl.ex_stall;
    assign bus.mem_stall    = ctl.mem_stall;
    assign bus.ex_mem_flush = ctl.ex_stall && !ctl.mem_stall;
    assign bus.state        = state_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule
